ct_ifu_ibuf_queue: RTL and testbench
====================================

Name: ct_ifu_ibuf_queue

Overview:
- Parametrised multi-entry instruction buffer: a circular queue of half-word entries between IFU fetch and decode.
- Replaces per-entry instantiation with one block that has a WR_W-wide write port and an RD_W-wide in-order read port.
- Provides all-or-nothing multi-entry push, variable-count pop, occupancy tracking and flush.
- Each entry carries a DATA_W payload: inst half-word, predecode bits and exception flags, packed by the producer.

Parameters:
DEPTH, 32, number of entries; power of two, 8..64
DATA_W, 40, payload bits per entry
WR_W, 8, max entries pushed per cycle; 1..DEPTH/2
RD_W, 6, entries presented to and poppable by the consumer per cycle; 1..DEPTH/2

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  asynchronous active-high reset
ibuf_flush  in  1  synchronous clear of all entries
wr_vld  in  1  push request
wr_num  in  $clog2(WR_W+1)  entries to push, 1..WR_W, lowest lanes first
wr_data  in  WR_W*DATA_W  lane i payload at [i*DATA_W +: DATA_W]
wr_rdy  out  1  space for a full WR_W push
rd_vld  out  RD_W  per-lane valid; thermometer code, lane 0 = oldest
rd_data  out  RD_W*DATA_W  oldest RD_W entries
rd_pop_num  in  $clog2(RD_W+1)  entries consumed this cycle
entry_cnt  out  $clog2(DEPTH+1)  occupancy
empty  out  1  entry_cnt==0
full  out  1  entry_cnt==DEPTH

Behaviour:
- State:
  - DEPTH x DATA_W storage.
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping mod DEPTH.
  - entry_cnt register.
- Reset (cpurst high, asynchronous): wr_ptr=0, rd_ptr=0, entry_cnt=0. Outputs then read empty=1, full=0, wr_rdy=1, rd_vld=0, rd_data=0.
  - Storage is not reset.
  - rd_data lanes with rd_vld=0 are forced to 0.
- Write readiness:
  - wr_rdy = (DEPTH - entry_cnt) >= WR_W, computed from registered state only.
  - Same-cycle pop does not create space for a same-cycle push.
- Push:
  - Accepted when wr_vld & wr_rdy & !ibuf_flush.
  - Lane i (i < wr_num) is written to entry (wr_ptr+i) mod DEPTH; wr_ptr advances by wr_num.
  - wr_num==0 with wr_vld is a no-op.
  - wr_num > WR_W is illegal: assertion fires; behaviour undefined.
  - Push while wr_rdy=0 is ignored. The producer must hold the request.
- Read lanes:
  - rd_vld[j] = (j < entry_cnt).
  - rd_data lane j = entry (rd_ptr+j) mod DEPTH.
  - Zero-latency combinational view of registered state; a pushed entry is first visible the cycle after the push.
- Pop:
  - rd_ptr advances by rd_pop_num.
  - Legal only if rd_pop_num <= popcount(rd_vld); assertion otherwise. The design clamps the pop to entry_cnt so the count never underflows.
- Count update: entry_cnt_next = entry_cnt + push_num - pop_num. Same-cycle push and pop are both applied.
- Wrap-around: pushes and reads straddling entry DEPTH-1 -> 0 use modulo indexing. No bubble, no reordering.
- Flush:
  - ibuf_flush has priority over push and pop.
  - Next cycle: wr_ptr=rd_ptr=0, entry_cnt=0, rd_vld=0.
  - Payload contents are left stale.
- Reset mid-operation: asserting cpurst at any time returns to the reset state immediately, without waiting for a clock edge.
- Invariant (asserted): entry_cnt == (wr_ptr - rd_ptr) mod DEPTH, except at full, where the pointers are equal and entry_cnt==DEPTH.

Optional Feature:
- Macro: CT_IFU_IBUF_BYPASS_EN.
- Defined:
  - When empty=1, wr_vld=1 and no flush, write lanes are forwarded combinationally to read lanes: rd_vld[j] = (j < wr_num), rd_data lane j = wr_data lane j.
  - The consumer may pop them in the same cycle.
  - Only unpopped lanes are stored: wr_ptr advances by wr_num, rd_ptr by rd_pop_num.
  - entry_cnt_next = wr_num - rd_pop_num.
  - Zero-latency through an empty queue.
- Undefined: no bypass; minimum push-to-read latency is 1 cycle.

Test Plan:
- Reset then push wr_num=8 with payloads 0x01..0x08, no pop -> next cycle entry_cnt=8, rd_vld=6'b111111, lanes = 0x01..0x06, wr_rdy=1.
- Fill to 25 entries (DEPTH-WR_W+1) -> wr_rdy=0. A push with wr_num=1 is ignored and entry_cnt stays 25. Pop 6 -> entry_cnt=19 and wr_rdy=1 next cycle.
- Wrap: set rd_ptr=wr_ptr=28 via prior traffic, push 8 entries 0xA0..0xA7 -> entries 28..31 and 0..3 hold them in order; rd lanes read 0xA0..0xA5.
- Simultaneous push 5 and pop 3 at entry_cnt=10 -> entry_cnt=12 and pointers advance by 5 and 3 respectively.
- ibuf_flush together with push 8 and pop 2 at entry_cnt=20 -> next cycle entry_cnt=0, empty=1, rd_vld=0, both pointers 0.
- With CT_IFU_IBUF_BYPASS_EN, empty queue, push 4 (0x11..0x14) and pop 2 in the same cycle -> same-cycle rd_vld=4'b1111 with lanes 0x11..0x14; next cycle entry_cnt=2, lanes = 0x13, 0x14. Without the macro, the same stimulus gives same-cycle rd_vld=0, the pop is clamped to 0 and the assertion fires.

Source files
------------

// File: rtl/ct_ifu_ibuf_queue_if.sv
// Fetch-to-decode instruction buffer bus: producer push port, consumer read/pop port, status.
// The master side is the IFU/decode pair; the slave side is ct_ifu_ibuf_queue.
interface ct_ifu_ibuf_queue_if #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 40,
  parameter int WR_W   = 8,
  parameter int RD_W   = 6
);
  localparam int WNW = $clog2(WR_W + 1);
  localparam int RNW = $clog2(RD_W + 1);
  localparam int CW  = $clog2(DEPTH + 1);

  logic                     ibuf_flush;
  logic                     wr_vld;
  logic [WNW-1:0]           wr_num;
  logic [WR_W*DATA_W-1:0]   wr_data;
  logic                     wr_rdy;
  logic [RD_W-1:0]          rd_vld;
  logic [RD_W*DATA_W-1:0]   rd_data;
  logic [RNW-1:0]           rd_pop_num;
  logic [CW-1:0]            entry_cnt;
  logic                     empty;
  logic                     full;

  modport master (
    output ibuf_flush, wr_vld, wr_num, wr_data, rd_pop_num,
    input  wr_rdy, rd_vld, rd_data, entry_cnt, empty, full
  );

  modport slave (
    input  ibuf_flush, wr_vld, wr_num, wr_data, rd_pop_num,
    output wr_rdy, rd_vld, rd_data, entry_cnt, empty, full
  );
endinterface

// File: rtl/ct_ifu_ibuf_queue.sv
// Circular instruction buffer: all-or-nothing WR_W-wide push, RD_W-wide in-order read, clamped pop.
// Optional macro CT_IFU_IBUF_BYPASS_EN forwards write lanes straight to read lanes when empty.
module ct_ifu_ibuf_queue #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 40,
  parameter int WR_W   = 8,
  parameter int RD_W   = 6
) (
  input logic                forever_cpuclk,
  input logic                cpurst,
  ct_ifu_ibuf_queue_if.slave ibuf
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WNW = $clog2(WR_W + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_cnt;

  logic              w_wr_rdy;
  logic              w_push;
  logic              w_byp;
  logic [CW-1:0]     w_push_num;
  logic [CW-1:0]     w_avail;
  logic [CW-1:0]     w_pop_req;
  logic [CW-1:0]     w_pop_num;
  logic [CW-1:0]     w_cnt_next;

  // Readiness looks only at registered occupancy so it never depends on the consumer this cycle.
  assign w_wr_rdy   = (r_cnt <= CW'(DEPTH - WR_W));
  assign w_push     = ibuf.wr_vld & w_wr_rdy & ~ibuf.ibuf_flush;
  assign w_push_num = w_push ? CW'(ibuf.wr_num) : '0;

`ifdef CT_IFU_IBUF_BYPASS_EN
  assign w_byp = (r_cnt == '0) & ibuf.wr_vld & ~ibuf.ibuf_flush;
`else
  assign w_byp = 1'b0;
`endif

  assign w_avail    = w_byp ? w_push_num : r_cnt;
  assign w_pop_req  = CW'(ibuf.rd_pop_num);
  assign w_pop_num  = (w_pop_req > w_avail) ? w_avail : w_pop_req;
  assign w_cnt_next = r_cnt + w_push_num - w_pop_num;

  genvar gi;
  generate
    for (gi = 0; gi < RD_W; gi++) begin : g_rd
      logic [PW-1:0]     w_idx;
      logic              w_q_vld;
      logic              w_lane_vld;
      logic [DATA_W-1:0] w_lane_data;

      assign w_idx   = r_rd_ptr + PW'(gi);
      assign w_q_vld = (r_cnt > CW'(gi));
`ifdef CT_IFU_IBUF_BYPASS_EN
      if (gi < WR_W) begin : g_byp
        assign w_lane_vld  = w_byp ? (CW'(ibuf.wr_num) > CW'(gi)) : w_q_vld;
        assign w_lane_data = w_byp ? ibuf.wr_data[gi*DATA_W +: DATA_W] : r_mem[w_idx];
      end else begin : g_nobyp
        assign w_lane_vld  = w_byp ? 1'b0 : w_q_vld;
        assign w_lane_data = r_mem[w_idx];
      end
`else
      assign w_lane_vld  = w_q_vld;
      assign w_lane_data = r_mem[w_idx];
`endif
      assign ibuf.rd_vld[gi]                    = w_lane_vld;
      assign ibuf.rd_data[gi*DATA_W +: DATA_W]  = w_lane_vld ? w_lane_data : '0;
    end
  endgenerate

  // Payload storage has no reset; stale contents are masked by rd_vld.
  always_ff @(posedge forever_cpuclk) begin
    if (w_push) begin
      for (int i = 0; i < WR_W; i++) begin
        if (WNW'(i) < ibuf.wr_num)
          r_mem[r_wr_ptr + PW'(i)] <= ibuf.wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (ibuf.ibuf_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_push_num);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop_num);
      r_cnt    <= w_cnt_next;
    end
  end

  assign ibuf.wr_rdy    = w_wr_rdy;
  assign ibuf.entry_cnt = r_cnt;
  assign ibuf.empty     = (r_cnt == '0);
  assign ibuf.full      = (r_cnt == CW'(DEPTH));

  a_wr_num: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    ibuf.wr_vld |-> (ibuf.wr_num <= WNW'(WR_W)));
  a_pop_legal: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    w_pop_req <= CW'($countones(ibuf.rd_vld)));
  // At full the low count bits wrap to zero, matching equal pointers.
  a_cnt_ptr: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    (r_cnt <= CW'(DEPTH)) && (r_cnt[PW-1:0] == PW'(r_wr_ptr - r_rd_ptr)));
endmodule

// File: tb/tb_ct_ifu_ibuf_queue.sv
// Scoreboard bench for ct_ifu_ibuf_queue: directed scenarios followed by constrained random traffic.
module tb_ct_ifu_ibuf_queue;
  localparam int DEPTH  = 32;
  localparam int DATA_W = 40;
  localparam int WR_W   = 8;
  localparam int RD_W   = 6;
  localparam int WNW    = $clog2(WR_W + 1);
  localparam int RNW    = $clog2(RD_W + 1);

  typedef logic [255:0] v_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ct_ifu_ibuf_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .WR_W(WR_W), .RD_W(RD_W)) ibuf ();

  ct_ifu_ibuf_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .WR_W(WR_W), .RD_W(RD_W)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .ibuf           (ibuf)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] lanes [WR_W];
  int m_wr = 0;
  int m_rd = 0;

  task automatic chk(input string tag, input v_t got, input v_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_byp(input int sz, input bit vld, input bit fl);
`ifdef CT_IFU_IBUF_BYPASS_EN
    return (sz == 0) && vld && !fl;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_lanes(input int base);
    for (int i = 0; i < WR_W; i++) lanes[i] = DATA_W'(base + i);
  endtask

  task automatic idle_inputs();
    ibuf.wr_vld     = 1'b0;
    ibuf.wr_num     = '0;
    ibuf.rd_pop_num = '0;
    ibuf.ibuf_flush = 1'b0;
  endtask

  // One clock of stimulus: check the pre-edge view against the scoreboard, then apply the edge.
  task automatic drive(input int n, input bit vld, input int pop, input bit fl);
    int sz, avail, p;
    bit byp, rdy;
    logic [RD_W-1:0] ev;
    logic [RD_W*DATA_W-1:0] ed;
    @(negedge clk);
    ibuf.wr_vld     = vld;
    ibuf.wr_num     = WNW'(n);
    for (int i = 0; i < WR_W; i++) ibuf.wr_data[i*DATA_W +: DATA_W] = lanes[i];
    ibuf.rd_pop_num = RNW'(pop);
    ibuf.ibuf_flush = fl;
    #1;
    sz  = sb.size();
    byp = exp_byp(sz, vld, fl);
    rdy = (DEPTH - sz) >= WR_W;
    ev  = '0;
    ed  = '0;
    for (int j = 0; j < RD_W; j++) begin
      if (byp) begin
        if (j < n) begin ev[j] = 1'b1; ed[j*DATA_W +: DATA_W] = lanes[j]; end
      end else if (j < sz) begin
        ev[j] = 1'b1; ed[j*DATA_W +: DATA_W] = sb[j];
      end
    end
    chk("wr_rdy", v_t'(ibuf.wr_rdy), v_t'(rdy));
    chk("entry_cnt", v_t'(ibuf.entry_cnt), v_t'(sz));
    chk("empty", v_t'(ibuf.empty), v_t'(sz == 0));
    chk("full", v_t'(ibuf.full), v_t'(sz == DEPTH));
    chk("rd_vld", v_t'(ibuf.rd_vld), v_t'(ev));
    chk("rd_data", v_t'(ibuf.rd_data), v_t'(ed));
    chk("wr_ptr", v_t'(dut.r_wr_ptr), v_t'(m_wr));
    chk("rd_ptr", v_t'(dut.r_rd_ptr), v_t'(m_rd));
    if (fl) begin
      sb.delete();
      m_wr = 0;
      m_rd = 0;
    end else begin
      avail = byp ? n : sz;
      p = (pop < avail) ? pop : avail;
      if (vld && rdy && n > 0) begin
        for (int i = 0; i < n; i++) sb.push_back(lanes[i]);
        m_wr = (m_wr + n) % DEPTH;
      end
      repeat (p) void'(sb.pop_front());
      m_rd = (m_rd + p) % DEPTH;
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 64) begin
      drive(0, 1'b0, (sb.size() < RD_W) ? sb.size() : RD_W, 1'b0);
      guard++;
    end
    chk("drain_done", v_t'(sb.size()), v_t'(0));
  endtask

  int w0, r0, sz, n, pop, vis, avail;
  bit vld, fl;
  logic [63:0] rnd;

  initial begin
    idle_inputs();
    ibuf.wr_data = '0;
    for (int i = 0; i < WR_W; i++) lanes[i] = '0;
    rst = 1'b1;
    #12;
    chk("rst_cnt", v_t'(ibuf.entry_cnt), v_t'(0));
    chk("rst_empty", v_t'(ibuf.empty), v_t'(1));
    chk("rst_full", v_t'(ibuf.full), v_t'(0));
    chk("rst_rdy", v_t'(ibuf.wr_rdy), v_t'(1));
    chk("rst_vld", v_t'(ibuf.rd_vld), v_t'(0));
    chk("rst_data", v_t'(ibuf.rd_data), v_t'(0));
    @(negedge clk);
    rst = 1'b0;

    // First push becomes visible one cycle later
    set_lanes(8'h01); drive(8, 1'b1, 0, 1'b0);
    chk("tp1_cnt", v_t'(ibuf.entry_cnt), v_t'(8));
    chk("tp1_vld", v_t'(ibuf.rd_vld), v_t'(6'h3f));
    chk("tp1_lane0", v_t'(ibuf.rd_data[0 +: DATA_W]), v_t'(8'h01));
    chk("tp1_lane5", v_t'(ibuf.rd_data[5*DATA_W +: DATA_W]), v_t'(8'h06));
    chk("tp1_rdy", v_t'(ibuf.wr_rdy), v_t'(1));

    // Fill to DEPTH-WR_W+1 and confirm back-pressure
    set_lanes(8'h09); drive(8, 1'b1, 0, 1'b0);
    set_lanes(8'h11); drive(8, 1'b1, 0, 1'b0);
    chk("at24_rdy", v_t'(ibuf.wr_rdy), v_t'(1));
    set_lanes(8'h19); drive(1, 1'b1, 0, 1'b0);
    chk("tp2_cnt", v_t'(ibuf.entry_cnt), v_t'(25));
    chk("tp2_rdy", v_t'(ibuf.wr_rdy), v_t'(0));
    set_lanes(8'h50); drive(1, 1'b1, 0, 1'b0);
    chk("tp2_ignored", v_t'(ibuf.entry_cnt), v_t'(25));
    drive(0, 1'b0, 6, 1'b0);
    chk("tp2_pop_cnt", v_t'(ibuf.entry_cnt), v_t'(19));
    chk("tp2_pop_rdy", v_t'(ibuf.wr_rdy), v_t'(1));
    set_lanes(8'h30); drive(5, 1'b1, 0, 1'b0);
    set_lanes(8'h40); drive(8, 1'b1, 0, 1'b0);
    chk("full_flag", v_t'(ibuf.full), v_t'(1));
    chk("full_rdy", v_t'(ibuf.wr_rdy), v_t'(0));
    drain();

    // Move both pointers to 28, then push across the wrap point
    set_lanes(8'h60); drive(8, 1'b1, 0, 1'b0);
    set_lanes(8'h68); drive(8, 1'b1, 0, 1'b0);
    set_lanes(8'h70); drive(6, 1'b1, 0, 1'b0);
    drain();
    chk("wrap_rptr", v_t'(dut.r_rd_ptr), v_t'(28));
    chk("wrap_wptr", v_t'(dut.r_wr_ptr), v_t'(28));
    set_lanes(8'hA0); drive(8, 1'b1, 0, 1'b0);
    chk("wrap_lane0", v_t'(ibuf.rd_data[0 +: DATA_W]), v_t'(8'hA0));
    chk("wrap_lane5", v_t'(ibuf.rd_data[5*DATA_W +: DATA_W]), v_t'(8'hA5));
    chk("wrap_mem28", v_t'(dut.r_mem[28]), v_t'(8'hA0));
    chk("wrap_mem31", v_t'(dut.r_mem[31]), v_t'(8'hA3));
    chk("wrap_mem0", v_t'(dut.r_mem[0]), v_t'(8'hA4));
    chk("wrap_mem3", v_t'(dut.r_mem[3]), v_t'(8'hA7));
    drive(0, 1'b0, 6, 1'b0);
    chk("wrap_tail", v_t'(ibuf.rd_data[0 +: DATA_W]), v_t'(8'hA6));

    // Concurrent push 5 / pop 3 at occupancy 10
    set_lanes(8'hB0); drive(8, 1'b1, 0, 1'b0);
    chk("pp_start", v_t'(ibuf.entry_cnt), v_t'(10));
    w0 = m_wr; r0 = m_rd;
    set_lanes(8'hC0); drive(5, 1'b1, 3, 1'b0);
    chk("pp_cnt", v_t'(ibuf.entry_cnt), v_t'(12));
    chk("pp_wptr", v_t'(dut.r_wr_ptr), v_t'((w0 + 5) % DEPTH));
    chk("pp_rptr", v_t'(dut.r_rd_ptr), v_t'((r0 + 3) % DEPTH));

    // Flush wins over same-cycle push and pop
    set_lanes(8'hD0); drive(8, 1'b1, 0, 1'b0);
    chk("fl_start", v_t'(ibuf.entry_cnt), v_t'(20));
    set_lanes(8'hE0); drive(8, 1'b1, 2, 1'b1);
    chk("fl_cnt", v_t'(ibuf.entry_cnt), v_t'(0));
    chk("fl_empty", v_t'(ibuf.empty), v_t'(1));
    chk("fl_vld", v_t'(ibuf.rd_vld), v_t'(0));
    chk("fl_wptr", v_t'(dut.r_wr_ptr), v_t'(0));
    chk("fl_rptr", v_t'(dut.r_rd_ptr), v_t'(0));

`ifdef CT_IFU_IBUF_BYPASS_EN
    set_lanes(8'h11); drive(4, 1'b1, 2, 1'b0);
    chk("byp_cnt", v_t'(ibuf.entry_cnt), v_t'(2));
    chk("byp_lane0", v_t'(ibuf.rd_data[0 +: DATA_W]), v_t'(8'h13));
    chk("byp_lane1", v_t'(ibuf.rd_data[DATA_W +: DATA_W]), v_t'(8'h14));
    drain();
`endif

    // Random legal traffic
    for (int c = 0; c < 400; c++) begin
      n   = $urandom_range(0, WR_W);
      vld = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 40) == 0);
      sz  = sb.size();
      avail = exp_byp(sz, vld, fl) ? n : sz;
      vis = (avail < RD_W) ? avail : RD_W;
      pop = $urandom_range(0, vis);
      for (int i = 0; i < WR_W; i++) begin
        rnd = {$urandom(), $urandom()};
        lanes[i] = rnd[DATA_W-1:0];
      end
      drive(n, vld, pop, fl);
    end

    // Asynchronous reset between clock edges
    set_lanes(8'h70); drive(8, 1'b1, 0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt", v_t'(ibuf.entry_cnt), v_t'(0));
    chk("arst_empty", v_t'(ibuf.empty), v_t'(1));
    chk("arst_vld", v_t'(ibuf.rd_vld), v_t'(0));
    sb.delete();
    m_wr = 0;
    m_rd = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    set_lanes(8'h21); drive(3, 1'b1, 0, 1'b0);
    drive(0, 1'b0, 3, 1'b0);
    drive(0, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
